// File: rtl/eei_pkg.sv
// Shared core types: address/instruction words plus the instruction-queue
// entry record and queue state encoding.
package eei;

  typedef logic [31:0] Addr;
  typedef logic [31:0] Inst;

  typedef struct packed {
    Addr  addr;
    Inst  inst;
    logic is_rvc;
  } InstQueueEntry;

  typedef enum logic {
    RUN  = 1'b0,
    SKIP = 1'b1
  } InstQueueState;

endpackage

// File: rtl/inst_queue_fifo.sv
// Generic power-of-two FIFO with synchronous clear and occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module inst_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push && !full)  wptr_d = wptr_q + 1'b1;
      if (pop  && !empty) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage has no reset; entries are only visible once the pointers
  // say they were written, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/core_inst_queue.sv
// Instruction queue between fetch and decode. On a hazard it flushes,
// pulses a redirect to the fetcher and drops responses until the new PC.
module core_inst_queue
  import eei::*;
#(
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  Addr                       i_addr,
  input  Inst                       i_inst,
  input  logic                      i_is_rvc,
  output logic                      o_rvalid,
  input  logic                      o_rready,
  output Addr                       o_raddr,
  output Inst                       o_rdata,
  output logic                      o_is_rvc,
  input  logic                      i_is_hazard,
  input  Addr                       i_next_pc,
  output logic                      o_redirect,
  output Addr                       o_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                      o_almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(InstQueueEntry);

  InstQueueState state_q, state_d;
  Addr           skip_pc_q, skip_pc_d;
  logic          redirect_q, redirect_d;
  Addr           redirect_pc_q, redirect_pc_d;

  InstQueueEntry wr_entry, rd_entry;
  logic [EW-1:0] rd_bits;
  logic          fifo_empty, fifo_full;
  logic          push, pop, addr_match;

  assign wr_entry = '{addr: i_addr, inst: i_inst, is_rvc: i_is_rvc};
  assign rd_entry = InstQueueEntry'(rd_bits);

  // In SKIP the queue is always empty, so accepting unconditionally is safe.
  assign i_ready    = (state_q == SKIP) ? 1'b1 : (!fifo_full && !i_is_hazard);
  assign addr_match = (i_addr == skip_pc_q);
  assign push       = i_valid && i_ready && !i_is_hazard
                      && ((state_q == RUN) || addr_match);

  assign o_rvalid   = !fifo_empty && !i_is_hazard;
  assign pop        = o_rvalid && o_rready;

  assign o_raddr       = rd_entry.addr;
  assign o_rdata       = rd_entry.inst;
  assign o_is_rvc      = rd_entry.is_rvc;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_almost_full = (o_count >= CW'(AFULL_LEVEL));

  inst_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_is_hazard),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_bits),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (o_count)
  );

  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    skip_pc_d     = skip_pc_q;
    redirect_pc_d = redirect_pc_q;
    redirect_d    = i_is_hazard;
    if (i_is_hazard) begin
      state_d       = SKIP;
      skip_pc_d     = i_next_pc;
      redirect_pc_d = i_next_pc;
    end else if (state_q == SKIP && i_valid && addr_match) begin
      state_d = RUN;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      skip_pc_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      skip_pc_q     <= skip_pc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_core_inst_queue.sv
// Directed, table-driven bench for core_inst_queue (DEPTH=4, AFULL_LEVEL=3)
// with hand-written sequences for wrap-around traffic and async reset.
module tb_core_inst_queue;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_inst;
  logic        i_is_rvc;
  logic        o_rvalid;
  logic        o_rready;
  logic [31:0] o_raddr;
  logic [31:0] o_rdata;
  logic        o_is_rvc;
  logic        i_is_hazard;
  logic [31:0] i_next_pc;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [2:0]  o_count;
  logic        o_almost_full;

  int errors = 0;
  int checks = 0;

  core_inst_queue #(.DEPTH(4), .AFULL_LEVEL(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .i_addr        (i_addr),
    .i_inst        (i_inst),
    .i_is_rvc      (i_is_rvc),
    .o_rvalid      (o_rvalid),
    .o_rready      (o_rready),
    .o_raddr       (o_raddr),
    .o_rdata       (o_rdata),
    .o_is_rvc      (o_is_rvc),
    .i_is_hazard   (i_is_hazard),
    .i_next_pc     (i_next_pc),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_count       (o_count),
    .o_almost_full (o_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        rr;
    logic        hz;
    logic [31:0] npc;
    logic        e_ready;
    logic        e_rvalid;
    logic [31:0] e_raddr;
    int          e_count;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_afull;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] a, logic rr, logic hz,
                              logic [31:0] npc, logic e_ready, logic e_rvalid,
                              logic [31:0] e_raddr, int e_count, logic e_redir,
                              logic [31:0] e_rpc, logic e_afull);
    vec_t r;
    r.v = v; r.a = a; r.rr = rr; r.hz = hz; r.npc = npc;
    r.e_ready = e_ready; r.e_rvalid = e_rvalid; r.e_raddr = e_raddr;
    r.e_count = e_count; r.e_redir = e_redir; r.e_rpc = e_rpc;
    r.e_afull = e_afull;
    return r;
  endfunction

  // Instruction word and compressed flag are derived from the PC so the
  // head payload can be predicted from the expected head address alone.
  function automatic logic [31:0] inst_of(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] a, logic rr, logic hz, logic [31:0] npc);
    i_valid     = v;
    i_addr      = a;
    i_inst      = inst_of(a);
    i_is_rvc    = a[2];
    o_rready    = rr;
    i_is_hazard = hz;
    i_next_pc   = npc;
  endtask

  logic [31:0] model_q[$];
  logic [31:0] next_addr;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("reset_count",  32'(o_count), 0);
    check("reset_rvalid", 32'(o_rvalid), 0);
    check("reset_ready",  32'(i_ready), 1);
    check("reset_redir",  32'(o_redirect), 0);
    check("reset_rpc",    o_redirect_pc, 0);
    check("reset_afull",  32'(o_almost_full), 0);
    @(negedge clk);
    rst = 1'b1;

    // fill / drain
    vecs.push_back(mk(1, 'h0,   0, 0, 0,      1, 1'b0, 0,      0, 0, 0,      0));
    vecs.push_back(mk(1, 'h4,   0, 0, 0,      1, 1'b1, 0,      1, 0, 0,      0));
    vecs.push_back(mk(1, 'h8,   0, 0, 0,      1, 1'b1, 0,      2, 0, 0,      0));
    vecs.push_back(mk(1, 'hC,   0, 0, 0,      1, 1'b1, 0,      3, 0, 0,      1));
    vecs.push_back(mk(0, 0,     0, 0, 0,      0, 1'b1, 0,      4, 0, 0,      1));
    vecs.push_back(mk(1, 'h10,  1, 0, 0,      0, 1'b1, 0,      4, 0, 0,      1));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'h4,    3, 0, 0,      1));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'h8,    2, 0, 0,      0));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'hC,    1, 0, 0,      0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b0, 0,      0, 0, 0,      0));
    // flush with three entries held, then stale filter
    vecs.push_back(mk(1, 'h20,  0, 0, 0,      1, 1'b0, 0,      0, 0, 0,      0));
    vecs.push_back(mk(1, 'h24,  0, 0, 0,      1, 1'b1, 'h20,   1, 0, 0,      0));
    vecs.push_back(mk(1, 'h28,  0, 0, 0,      1, 1'b1, 'h20,   2, 0, 0,      0));
    vecs.push_back(mk(0, 0,     1, 1, 'h100,  0, 1'b0, 0,      3, 0, 0,      1));
    vecs.push_back(mk(1, 'h10,  0, 0, 0,      1, 1'b0, 0,      0, 1, 'h100,  0));
    vecs.push_back(mk(1, 'h14,  0, 0, 0,      1, 1'b0, 0,      0, 0, 'h100,  0));
    vecs.push_back(mk(1, 'h100, 0, 0, 0,      1, 1'b0, 0,      0, 0, 'h100,  0));
    vecs.push_back(mk(1, 'h104, 0, 0, 0,      1, 1'b1, 'h100,  1, 0, 'h100,  0));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'h100,  2, 0, 'h100,  0));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'h104,  1, 0, 'h100,  0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b0, 0,      0, 0, 'h100,  0));
    // back-to-back hazards: last target wins
    vecs.push_back(mk(0, 0,     0, 1, 'h200,  0, 1'b0, 0,      0, 0, 'h100,  0));
    vecs.push_back(mk(0, 0,     0, 1, 'h300,  1, 1'b0, 0,      0, 1, 'h200,  0));
    vecs.push_back(mk(1, 'h200, 0, 0, 0,      1, 1'b0, 0,      0, 1, 'h300,  0));
    vecs.push_back(mk(1, 'h300, 0, 0, 0,      1, 1'b0, 0,      0, 0, 'h300,  0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b1, 'h300,  1, 0, 'h300,  0));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'h300,  1, 0, 'h300,  0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b0, 0,      0, 0, 'h300,  0));
    // hazard coinciding with a matching response in SKIP: response dropped
    vecs.push_back(mk(0, 0,     0, 1, 'h400,  0, 1'b0, 0,      0, 0, 'h300,  0));
    vecs.push_back(mk(1, 'h400, 0, 1, 'h400,  1, 1'b0, 0,      0, 1, 'h400,  0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b0, 0,      0, 1, 'h400,  0));
    vecs.push_back(mk(1, 'h400, 0, 0, 0,      1, 1'b0, 0,      0, 0, 'h400,  0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b1, 'h400,  1, 0, 'h400,  0));
    vecs.push_back(mk(0, 0,     1, 0, 0,      1, 1'b1, 'h400,  1, 0, 'h400,  0));
    vecs.push_back(mk(0, 0,     0, 0, 0,      1, 1'b0, 0,      0, 0, 'h400,  0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].a, vecs[i].rr, vecs[i].hz, vecs[i].npc);
      #1;
      check($sformatf("v%0d_ready", i),  32'(i_ready),       32'(vecs[i].e_ready));
      check($sformatf("v%0d_rvalid", i), 32'(o_rvalid),      32'(vecs[i].e_rvalid));
      check($sformatf("v%0d_count", i),  32'(o_count),       32'(vecs[i].e_count));
      check($sformatf("v%0d_redir", i),  32'(o_redirect),    32'(vecs[i].e_redir));
      check($sformatf("v%0d_rpc", i),    o_redirect_pc,      vecs[i].e_rpc);
      check($sformatf("v%0d_afull", i),  32'(o_almost_full), 32'(vecs[i].e_afull));
      if (vecs[i].e_rvalid) begin
        check($sformatf("v%0d_raddr", i), o_raddr,       vecs[i].e_raddr);
        check($sformatf("v%0d_rdata", i), o_rdata,       inst_of(vecs[i].e_raddr));
        check($sformatf("v%0d_rvc", i),   32'(o_is_rvc), 32'(vecs[i].e_raddr[2]));
      end
    end

    // concurrent push/pop at occupancy 2, crossing pointer wrap repeatedly
    next_addr = 32'h500;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, next_addr, 0, 0, 0);
      model_q.push_back(next_addr);
      next_addr += 4;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1, next_addr, 1, 0, 0);
      #1;
      check($sformatf("cc%0d_count", k), 32'(o_count), 2);
      check($sformatf("cc%0d_ready", k), 32'(i_ready), 1);
      check($sformatf("cc%0d_raddr", k), o_raddr, model_q[0]);
      check($sformatf("cc%0d_rdata", k), o_rdata, inst_of(model_q[0]));
      void'(model_q.pop_front());
      model_q.push_back(next_addr);
      next_addr += 4;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    check("cc_end_count", 32'(o_count), 2);
    check("cc_end_raddr", o_raddr, model_q[0]);

    // async reset mid-cycle with two entries held
    #2;
    rst = 1'b0;
    #1;
    check("areset_count",  32'(o_count), 0);
    check("areset_rvalid", 32'(o_rvalid), 0);
    check("areset_ready",  32'(i_ready), 1);
    check("areset_redir",  32'(o_redirect), 0);
    check("areset_rpc",    o_redirect_pc, 0);
    check("areset_afull",  32'(o_almost_full), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1, 'h600, 0, 0, 0);
    #1;
    check("post_reset_ready", 32'(i_ready), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    check("post_reset_raddr", o_raddr, 32'h600);
    check("post_reset_count", 32'(o_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_inst_queue.md
# core_inst_queue

Parametrised instruction queue between the fetch unit and the core's decode stage, replacing the single-entry fetch handshake. It buffers up to DEPTH fetched instructions (address, word, compressed flag) and presents them in order to the core. On a core hazard/redirect it flushes all entries, issues a one-cycle redirect to the fetcher, and discards stale in-flight fetch responses until the first response at the new PC arrives.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- AFULL_LEVEL, DEPTH-1, count at or above which o_almost_full is high; 1..DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  fetcher presents a response
- i_ready  out  1  queue accepts the response this cycle
- i_addr  in  Addr  PC of the response
- i_inst  in  Inst  instruction word
- i_is_rvc  in  1  response is a 16-bit compressed instruction
- o_rvalid  out  1  head entry valid toward core
- o_rready  in  1  core consumes head
- o_raddr  out  Addr  head PC
- o_rdata  out  Inst  head instruction
- o_is_rvc  out  1  head compressed flag
- i_is_hazard  in  1  core requests flush and redirect
- i_next_pc  in  Addr  redirect target, sampled when i_is_hazard=1
- o_redirect  out  1  one-cycle pulse to fetcher: restart at o_redirect_pc
- o_redirect_pc  out  Addr  redirect target
- o_count  out  $clog2(DEPTH+1)  entries held
- o_almost_full  out  1  o_count ≥ AFULL_LEVEL

## Operation
- Storage: DEPTH-entry array of {Addr, Inst, is_rvc}; read/write pointers of $clog2(DEPTH)+1 bits; wrap-around by natural overflow; empty when pointers equal, full when index bits equal and MSBs differ.
- States: RUN, SKIP. Reset → RUN.
- RUN: push = i_valid & i_ready; i_ready = !full & !i_is_hazard (no dependence on o_rready; push into a full queue is refused even if a pop occurs that cycle). Pop = o_rvalid & o_rready.
- o_rvalid = !empty & !i_is_hazard; o_raddr/o_rdata/o_is_rvc driven combinationally from the head entry.
- i_is_hazard=1 (either state): at the next edge pointers reset (queue empty), any push/pop that cycle ignored, skip_pc ← i_next_pc, o_redirect ← 1, o_redirect_pc ← i_next_pc, state → SKIP.
- SKIP: i_ready = 1 (stale responses are drained, never back-pressured); a response with i_addr ≠ skip_pc is dropped; a response with i_addr == skip_pc is enqueued and state → RUN the same edge.
- o_count = wptr − rptr; o_almost_full registered-free, from o_count.

## Timing
- Reset values: state RUN, pointers 0, o_count 0, o_rvalid 0, o_redirect 0, o_redirect_pc 0, o_almost_full 0 (AFULL_LEVEL ≥ 1), i_ready 1.
- Push at edge t → o_rvalid high in cycle t+1 (one-cycle latency, no bypass from i_inst to o_rdata).
- Full queue: pop at edge t → i_ready high in cycle t+1.
- Simultaneous push and pop when neither full nor empty: o_count unchanged.
- o_redirect high exactly one cycle, the cycle after i_is_hazard; back-to-back hazards yield back-to-back pulses, last i_next_pc wins for skip_pc.
- Hazard and matching response in the same cycle: response dropped; match checked from the next cycle.
- Reset asserted mid-operation: all state cleared asynchronously, pending redirect lost.

## Structure
- In eei: Addr, Inst (existing); new InstQueueEntry packed struct {addr, inst, is_rvc}; InstQueueState enum {RUN, SKIP}.
- One sub-module natural: inst_queue_fifo (generic DEPTH/width FIFO with synchronous clear, count); state machine and skip filter in core_inst_queue.

## Test plan
- Fill/drain: DEPTH=4, push PCs 0x0,0x4,0x8,0xC with o_rready=0 → i_ready=0, o_count=4, o_almost_full=1; then o_rready=1 → PCs popped in order, o_rvalid 0 after the 4th.
- Concurrent traffic: push and pop every cycle for 20 cycles at o_count=2 → o_count stays 2, order preserved across pointer wrap.
- Flush: 3 entries held, i_is_hazard=1, i_next_pc=0x100 → o_rvalid=0 that cycle, next cycle o_count=0, o_redirect=1, o_redirect_pc=0x100.
- Stale filter: after flush to 0x100, responses at 0x10,0x14 then 0x100,0x104 → only 0x100,0x104 enqueued, i_ready stays 1 throughout SKIP.
- Double hazard: hazards to 0x200 then 0x300 in consecutive cycles, then responses 0x200,0x300 → 0x200 dropped, 0x300 enqueued, two o_redirect pulses.
- Async reset mid-fill with 2 entries → outputs reach reset values before the next clk edge.
